// File: rtl/m8_32.sv
// Byte-to-word packer for the PCIe PHY receive lane: gathers four valid bytes
// on clk_4f into one registered 32-bit word, flagging words abandoned mid-way.
module m8_32 #(
  parameter int unsigned BYTES     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_8_32_in,
  input  logic        valid_8_32_in,
  output logic [31:0] data_8_32,
  output logic        valid_8_32,
  output logic        err_partial
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } cnt_t;

  cnt_t        cnt, cnt_next;
  logic [31:0] shift_buf, shift_buf_next;
  logic [31:0] data_next;
  logic        valid_next;
  logic        err_next;
  int unsigned idx;

  // Bit offset of byte slot k within the word, honouring the byte order.
  function automatic int unsigned slot_lo(input int unsigned k);
    if (MSB_FIRST)
      return (BYTES - 1 - k) * 8;
    else
      return k * 8;
  endfunction

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cnt         <= S0;
      shift_buf   <= '0;
      data_8_32   <= '0;
      valid_8_32  <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      shift_buf   <= shift_buf_next;
      data_8_32   <= data_next;
      valid_8_32  <= valid_next;
      err_partial <= err_next;
    end
  end

  always_comb begin
    cnt_next       = cnt;
    shift_buf_next = shift_buf;
    data_next      = data_8_32;
    valid_next     = 1'b0;
    err_next       = 1'b0;
    idx            = 32'(cnt);

    if (valid_8_32_in) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (k == idx)
          shift_buf_next[slot_lo(k) +: 8] = data_8_32_in;
      end
      case (cnt)
        S0: cnt_next = S1;
        S1: cnt_next = S2;
        S2: cnt_next = S3;
        default: begin
          // The completed word is the buffer with the last byte already merged.
          cnt_next   = S0;
          data_next  = shift_buf_next;
          valid_next = 1'b1;
        end
      endcase
    end else if (cnt != S0) begin
      cnt_next = S0;
      err_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_m8_32.sv
// Bench for m8_32: queue-based reference model checked every cycle against an
// MSB-first and an LSB-first instance, plus directed literal expectations.
module tb_m8_32;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic        vin;
  logic [31:0] data_m, data_l;
  logic        valid_m, valid_l;
  logic        err_m, err_l;

  int checks = 0;
  int errors = 0;

  m8_32 #(.BYTES(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .data_8_32_in  (din),
    .valid_8_32_in (vin),
    .data_8_32     (data_m),
    .valid_8_32    (valid_m),
    .err_partial   (err_m)
  );

  m8_32 #(.BYTES(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .data_8_32_in  (din),
    .valid_8_32_in (vin),
    .data_8_32     (data_l),
    .valid_8_32    (valid_l),
    .err_partial   (err_l)
  );

  always #5 clk_4f = ~clk_4f;

  // Reference model: bytes gathered in a queue, word built on the fourth.
  logic [7:0]  q[$];
  logic [31:0] m_data_m = '0, m_data_l = '0;
  logic        m_valid = 1'b0, m_err = 1'b0;
  int          err_pulses = 0, word_pulses = 0;

  always @(posedge clk_4f) begin
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (reset) begin
      q.delete();
      m_data_m = '0;
      m_data_l = '0;
    end else if (vin) begin
      q.push_back(din);
      if (q.size() == 4) begin
        m_data_m = {q[0], q[1], q[2], q[3]};
        m_data_l = {q[3], q[2], q[1], q[0]};
        m_valid  = 1'b1;
        q.delete();
      end
    end else if (q.size() != 0) begin
      m_err = 1'b1;
      q.delete();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_4f) begin
    check("model data msb", data_m, m_data_m);
    check("model data lsb", data_l, m_data_l);
    check("model valid msb", {31'b0, valid_m}, {31'b0, m_valid});
    check("model valid lsb", {31'b0, valid_l}, {31'b0, m_valid});
    check("model err msb", {31'b0, err_m}, {31'b0, m_err});
    check("model err lsb", {31'b0, err_l}, {31'b0, m_err});
    if (valid_m === 1'b1) word_pulses++;
    if (err_m === 1'b1) err_pulses++;
  end

  // Inputs are applied after a falling edge and held through the next rising edge.
  task automatic send(input logic [7:0] b);
    reset = 1'b0; vin = 1'b1; din = b;
    @(negedge clk_4f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; vin = 1'b0; din = 8'h00;
      @(negedge clk_4f);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
  endtask

  logic [31:0] rw;
  int          pulses_before;

  initial begin
    reset = 1'b1; vin = 1'b1; din = 8'hFF;
    @(negedge clk_4f);
    @(negedge clk_4f);
    check("reset data", data_m, 32'h0);
    check("reset valid", {31'b0, valid_m}, 32'h0);

    send_word(32'hDEADBEEF);
    check("single word msb", data_m, 32'hDEADBEEF);
    check("single word lsb", data_l, 32'hEFBEADDE);
    check("single word valid", {31'b0, valid_m}, 32'h1);
    idle(2);
    check("single word hold", data_m, 32'hDEADBEEF);
    check("valid drops", {31'b0, valid_m}, 32'h0);

    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("stream word 0", data_m, 32'h01020304);
    send(8'h05); send(8'h06); send(8'h07);
    check("stream no early pulse", {31'b0, valid_m}, 32'h0);
    send(8'h08);
    check("stream word 1", data_m, 32'h05060708);

    send(8'hAA); send(8'hBB);
    idle(1);
    check("abort err", {31'b0, err_m}, 32'h1);
    check("abort data held", data_m, 32'h05060708);
    send_word(32'h11223344);
    check("after abort", data_m, 32'h11223344);

    pulses_before = err_pulses;
    send_word(32'h0BADF00D);
    idle(5);
    send_word(32'h600DCAFE);
    check("gap word", data_m, 32'h600DCAFE);
    check("gap no err", err_pulses - pulses_before, 0);

    pulses_before = err_pulses;
    send(8'h12); send(8'h34); send(8'h56);
    reset = 1'b1; vin = 1'b1; din = 8'h99;
    @(negedge clk_4f);
    check("mid reset data", data_m, 32'h0);
    send_word(32'hCAFEBABE);
    check("after mid reset", data_m, 32'hCAFEBABE);
    check("after mid reset lsb", data_l, 32'hBEBAFECA);
    check("mid reset no err", err_pulses - pulses_before, 0);

    pulses_before = word_pulses;
    for (int i = 0; i < 8; i++) begin
      rw = $urandom;
      send_word(rw);
      check("random word", data_m, rw);
    end
    check("random pulse count", word_pulses - pulses_before, 8);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
